// File: rtl/rr_arb8_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the eight-way round-robin arbiter.
//   - N_REQ / IDX_W : requester count and grant-index width
//   - arb_state_t   : arbiter FSM states
//   - rr_pick()     : rotating-priority search used for every new grant
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Scan ptr+1, ptr+2, ... wrapping, with ptr itself examined last.
    // When excl_valid is set, index excl is skipped (a holder whose hold
    // time just expired may not win again on that edge). If nothing is
    // eligible the pointer is returned; callers only use the result when
    // at least one eligible request exists.
    function automatic idx_t rr_pick(
        input req_vec_t req,
        input idx_t     ptr,
        input logic     excl_valid,
        input idx_t     excl
    );
        idx_t pick;
        idx_t idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr + idx_t'(k);
            if (!found && req[idx] && !(excl_valid && (idx == excl))) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // True when some request other than index c is pending.
    function automatic logic others_pending(input req_vec_t req, input idx_t c);
        return |(req & ~(req_vec_t'(1) << c));
    endfunction

endpackage

// File: rtl/rr_arb8_if.sv
// -----------------------------------------------------------------------------
// rr_arb8_if
//   Request/grant bundle between the requesters and the arbiter.
//   - req    : level request lines, one per requester
//   - gnt    : one-hot grant, all zero when idle
//   - gnt_id : index of the current grantee (valid while busy)
//   - busy   : a grant is active
//   master : requester side (drives req)
//   slave  : arbiter side (drives gnt, gnt_id, busy)
// -----------------------------------------------------------------------------
interface rr_arb8_if;
    import arb_pkg::*;

    req_vec_t req;
    req_vec_t gnt;
    idx_t     gnt_id;
    logic     busy;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy
    );

endinterface

// File: rtl/rr_arb8_dec3to8.sv
// -----------------------------------------------------------------------------
// dec3to8
//   3-to-8 one-hot decoder with enable.
//   - din  : binary index
//   - en   : when low, the output is all zero
//   - dout : one-hot of din when enabled
// -----------------------------------------------------------------------------
module dec3to8
    import arb_pkg::*;
(
    input  idx_t     din,
    input  logic     en,
    output req_vec_t dout
);

    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        dout = '0;
        if (en) begin
            dout[din] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// -----------------------------------------------------------------------------
// rr_arb8
//   Eight-way round-robin arbiter with bounded hold time. A grantee keeps
//   the resource while its request stays high, but for at most HOLD_MAX
//   consecutive cycles while anybody else is waiting. Priority rotates
//   from the last-served requester.
//   Parameters:
//   - HOLD_MAX : max consecutive contended grant cycles (1..255)
//   Ports:
//   - clk   : rising-edge clock
//   - rst_n : asynchronous active-low reset
//   - bus   : rr_arb8_if.slave (req in; gnt, gnt_id, busy out)
// -----------------------------------------------------------------------------
module rr_arb8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    rr_arb8_if.slave   bus
);

    // Hold counter only needs to reach HOLD_MAX-1; keep at least one bit.
    localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

    generate
        if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("rr_arb8: HOLD_MAX must be in 1..255");
        end
    endgenerate

    arb_state_t      state_q, state_d;
    idx_t            gnt_id_q, gnt_id_d;
    idx_t            ptr_q, ptr_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic     holder_req;
    logic     contended;
    logic     busy;
    req_vec_t gnt;

    assign holder_req = bus.req[gnt_id_q];
    assign contended  = others_pending(bus.req, gnt_id_q);

    // Next-state and next-register logic.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = GRANT;
                    gnt_id_d = rr_pick(bus.req, ptr_q, 1'b0, '0);
                    hold_d   = '0;
                end
            end

            GRANT: begin
                if (!holder_req) begin
                    // Release: hand over without an idle cycle if possible.
                    ptr_d  = gnt_id_q;
                    hold_d = '0;
                    if (|bus.req) begin
                        gnt_id_d = rr_pick(bus.req, gnt_id_q, 1'b0, '0);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (contended && (hold_q == HOLD_LAST)) begin
                    // Expire: the holder is excluded from this search.
                    ptr_d    = gnt_id_q;
                    gnt_id_d = rr_pick(bus.req, gnt_id_q, 1'b1, gnt_id_q);
                    hold_d   = '0;
                end else if (hold_q != HOLD_LAST) begin
                    // Contended and below the limit, or uncontested and not
                    // yet saturated. An uncontested holder parks at
                    // HOLD_LAST, so a newcomer takes over on the next edge.
                    hold_d = hold_q + HC_W'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            ptr_q    <= idx_t'(N_REQ - 1);
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign busy = (state_q == GRANT);

    // Grant vector decoded purely from registers, so it is glitch-free.
    dec3to8 u_dec (
        .din  (gnt_id_q),
        .en   (busy),
        .dout (gnt)
    );

    assign bus.gnt    = gnt;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy;

    a_gnt_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt)
    );

    a_busy_matches_gnt : assert property (
        @(posedge clk) disable iff (!rst_n) bus.busy == (bus.gnt != '0)
    );

endmodule

// File: tb/tb_rr_arb8.sv
// -----------------------------------------------------------------------------
// tb_rr_arb8
//   Drives three arbiters (HOLD_MAX = 4, 1, 5) from one request vector and
//   compares each against a cycle-level reference model of the arbitration
//   rules. Inputs change on the falling edge; outputs are compared on the
//   following falling edge.
// -----------------------------------------------------------------------------
module tb_rr_arb8;

    localparam int N_DUT = 3;
    localparam int HM [N_DUT] = '{4, 1, 5};

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb8_if b0 ();
    rr_arb8_if b1 ();
    rr_arb8_if b2 ();

    assign b0.req = req;
    assign b1.req = req;
    assign b2.req = req;

    rr_arb8 #(.HOLD_MAX(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    rr_arb8 #(.HOLD_MAX(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    rr_arb8 #(.HOLD_MAX(5)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    logic [7:0] o_gnt  [N_DUT];
    logic [2:0] o_id   [N_DUT];
    logic       o_busy [N_DUT];

    assign o_gnt[0] = b0.gnt;  assign o_id[0] = b0.gnt_id;  assign o_busy[0] = b0.busy;
    assign o_gnt[1] = b1.gnt;  assign o_id[1] = b1.gnt_id;  assign o_busy[1] = b1.busy;
    assign o_gnt[2] = b2.gnt;  assign o_id[2] = b2.gnt_id;  assign o_busy[2] = b2.busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // m_run counts how many edges the current holder has already kept the
    // grant beyond its first cycle, capped at HOLD_MAX-1.
    int m_busy [N_DUT];
    int m_id   [N_DUT];
    int m_ptr  [N_DUT];
    int m_run  [N_DUT];

    function automatic int pick(input logic [7:0] r, input int start, input int skip);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (start + k) % 8;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N_DUT; n++) begin
            m_busy[n] = 0;
            m_id[n]   = 0;
            m_ptr[n]  = 7;
            m_run[n]  = 0;
        end
    endtask

    task automatic model_update(input logic [7:0] r);
        for (int n = 0; n < N_DUT; n++) begin
            int c;
            logic [7:0] others;
            if (m_busy[n] == 0) begin
                if (r != 0) begin
                    m_busy[n] = 1;
                    m_id[n]   = pick(r, m_ptr[n] + 1, -1);
                    m_run[n]  = 0;
                end
            end else begin
                c      = m_id[n];
                others = r & ~(8'(1) << c);
                if (!r[c]) begin
                    m_ptr[n] = c;
                    m_run[n] = 0;
                    if (r != 0) m_id[n] = pick(r, c + 1, -1);
                    else        m_busy[n] = 0;
                end else if (others != 0 && m_run[n] >= HM[n] - 1) begin
                    m_ptr[n] = c;
                    m_id[n]  = pick(r, c + 1, c);
                    m_run[n] = 0;
                end else begin
                    m_run[n] = (m_run[n] + 1 > HM[n] - 1) ? HM[n] - 1 : m_run[n] + 1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int n = 0; n < N_DUT; n++) begin
            logic [7:0] exp_gnt;
            exp_gnt = (m_busy[n] != 0) ? 8'(8'(1) << m_id[n]) : 8'h00;
            check($sformatf("busy[%0d]", n), 32'(o_busy[n]), 32'(m_busy[n]));
            check($sformatf("gnt[%0d]", n), 32'(o_gnt[n]), 32'(exp_gnt));
            if (m_busy[n] != 0)
                check($sformatf("gnt_id[%0d]", n), 32'(o_id[n]), 32'(m_id[n]));
        end
    endtask

    // Drive r on the falling edge, model the next rising edge, compare on
    // the following falling edge.
    task automatic cycle(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_update(r);
        @(negedge clk);
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] r;

        // Reset held with every request high.
        rst_n = 1'b0;
        req   = 8'hFF;
        model_reset();
        @(negedge clk);
        compare_all();
        check("rst_gnt", 32'(o_gnt[0]), 32'h00);
        check("rst_busy", 32'(o_busy[0]), 32'h0);
        rst_n = 1'b1;
        cycle(8'hFF);
        check("first_gnt", 32'(o_gnt[0]), 32'h01);

        // Full contention: 0..7,0 each held HOLD_MAX cycles (model checks).
        for (int i = 0; i < 34; i++) cycle(8'hFF);

        // Single requester held: never expires.
        for (int i = 0; i < 12; i++) begin
            cycle(8'h20);
            if (i > 0) begin
                check("single_gnt", 32'(o_gnt[0]), 32'h20);
                check("single_id", 32'(o_id[0]), 32'd5);
            end
        end

        // Release handover 2 -> 7 -> 0.
        cycle(8'h04);
        check("rel_setup", 32'(o_gnt[0]), 32'h04);
        cycle(8'h81);
        check("rel_to7", 32'(o_gnt[0]), 32'h80);
        cycle(8'h01);
        check("rel_to0", 32'(o_gnt[0]), 32'h01);

        // All requests drop together, then a fresh request.
        cycle(8'h00);
        check("drop_busy", 32'(o_busy[0]), 32'h0);
        check("drop_gnt", 32'(o_gnt[0]), 32'h00);
        cycle(8'h08);
        check("new_gnt", 32'(o_gnt[0]), 32'h08);

        // Asynchronous reset between edges while granted.
        cycle(8'hFF);
        cycle(8'hFF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < N_DUT; n++) begin
            check($sformatf("async_busy[%0d]", n), 32'(o_busy[n]), 32'h0);
            check($sformatf("async_gnt[%0d]", n), 32'(o_gnt[n]), 32'h00);
        end
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        cycle(8'hFF);
        check("restart_gnt", 32'(o_gnt[0]), 32'h01);

        // Randomized traffic with persistent requests and holder releases.
        r = 8'hFF;
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 15))
                0:       r = 8'($urandom);
                1:       r = 8'h00;
                2, 3, 4: r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
                5:       if (m_busy[0] != 0) r[m_id[0]] = 1'b0;
                6:       r[$urandom_range(0, 7)] = 1'b1;
                default: ;
            endcase
            cycle(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
